// File: rtl/lbp_pkg.sv
// Shared constants, FSM states and address helpers
// for the LBP histogram accumulator.
package lbp_pkg;

  localparam int IMG_W  = 128;
  localparam int BIN_N  = 256;
  localparam int CNT_W  = 14;
  localparam int ADDR_W = 14;

  typedef enum logic [2:0] {
    ACCUM,
    FLUSH,
    DRAIN_RD,
    DRAIN_OUT,
    DONE
  } hist_state_t;

  // True when row and col are both in 1..img_w-2.
  function automatic logic is_interior(
    input logic [ADDR_W-1:0] addr,
    input int                img_w
  );
    int row;
    int col;
    row = int'(addr) / img_w;
    col = int'(addr) % img_w;
    return (row >= 1) && (row <= img_w - 2) &&
           (col >= 1) && (col <= img_w - 2);
  endfunction

endpackage

// File: rtl/lbp_hist_ram.sv
// Bin count storage: 1-cycle sync read, one write port,
// read-before-write on a same-address collision.
module lbp_hist_ram
  import lbp_pkg::*;
#(
  parameter int CNT_W = lbp_pkg::CNT_W
)(
  input  logic             clk,
  input  logic             rd_en,
  input  logic [7:0]       rd_addr,
  output logic [CNT_W-1:0] rd_data,
  input  logic             wr_en,
  input  logic [7:0]       wr_addr,
  input  logic [CNT_W-1:0] wr_data
);

  logic [CNT_W-1:0] mem [BIN_N];

  // Read returns the pre-write contents of the same edge.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

endmodule

// File: rtl/lbp_histogram.sv
// 256-bin LBP code histogram with protocol checking and
// a valid/ready drain of all bins after finish.
module lbp_histogram
  import lbp_pkg::*;
#(
  parameter int IMG_W = lbp_pkg::IMG_W,
  parameter int CNT_W = lbp_pkg::CNT_W
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              lbp_valid,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic [7:0]        lbp_data,
  input  logic              finish,
  output logic              hist_valid,
  input  logic              hist_ready,
  output logic [7:0]        hist_bin,
  output logic [CNT_W-1:0]  hist_count,
  output logic              hist_last,
  output logic [CNT_W-1:0]  pix_count,
  output logic              proto_err,
  output logic              done
);

  hist_state_t      state;
  hist_state_t      state_nx;
  logic [7:0]       k;
  logic [BIN_N-1:0] flags;

  logic             s1_valid;
  logic [7:0]       s1_bin;
  logic             fw_valid;
  logic [7:0]       fw_bin;
  logic [CNT_W-1:0] fw_data;

  logic [CNT_W-1:0] rd_data;
  logic [CNT_W-1:0] old_cnt;
  logic [CNT_W-1:0] new_cnt;
  logic             accept;
  logic             rd_en;
  logic [7:0]       rd_addr;
  logic             hs;

  assign accept  = lbp_valid && (state == ACCUM) &&
                   is_interior(lbp_addr, IMG_W);
  assign rd_en   = accept || (state == DRAIN_RD);
  assign rd_addr = (state == DRAIN_RD) ? k : lbp_data;
  assign hs      = (state == DRAIN_OUT) && hist_ready;

  lbp_hist_ram #(
    .CNT_W (CNT_W)
  ) u_ram (
    .clk     (clk),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (s1_valid),
    .wr_addr (s1_bin),
    .wr_data (new_cnt)
  );

  // Stage-2 old value: forward last write, else mask unwritten bins.
  always_comb begin
    old_cnt = '0;
    if (fw_valid && (fw_bin == s1_bin)) begin
      old_cnt = fw_data;
    end else if (flags[s1_bin]) begin
      old_cnt = rd_data;
    end
    new_cnt = old_cnt + CNT_W'(1);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ACCUM;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      ACCUM:     if (finish) state_nx = FLUSH;
      FLUSH:     state_nx = DRAIN_RD;
      DRAIN_RD:  state_nx = DRAIN_OUT;
      DRAIN_OUT: begin
        if (hist_ready) begin
          state_nx = (k == 8'hFF) ? DONE : DRAIN_RD;
        end
      end
      DONE:      state_nx = DONE;
      default:   state_nx = ACCUM;
    endcase
  end

  // Accumulate pipeline, flags, counters and sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_bin    <= '0;
      fw_valid  <= 1'b0;
      fw_bin    <= '0;
      fw_data   <= '0;
      flags     <= '0;
      pix_count <= '0;
      proto_err <= 1'b0;
    end else begin
      s1_valid <= accept;
      s1_bin   <= lbp_data;
      fw_valid <= s1_valid;
      fw_bin   <= s1_bin;
      fw_data  <= new_cnt;
      if (s1_valid) begin
        flags[s1_bin] <= 1'b1;
        if (pix_count != '1) pix_count <= pix_count + CNT_W'(1);
      end
      if (lbp_valid && !accept) proto_err <= 1'b1;
    end
  end

  // Drain bin index advances on each handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   k <= '0;
    else if (hs) k <= k + 8'd1;
  end

  assign hist_valid = (state == DRAIN_OUT);
  assign hist_bin   = hist_valid ? k : '0;
  assign hist_count = (hist_valid && flags[k]) ? rd_data : '0;
  assign hist_last  = hist_valid && (k == 8'hFF);
  assign done       = (state == DONE);

endmodule

// File: tb/tb_lbp_histogram.sv
// Scoreboard bench for lbp_histogram: model histogram
// pushed as expected beats, compared on each drain beat.
module tb_lbp_histogram;

  localparam int CNT_W = 14;

  logic             clk = 1'b0;
  logic             reset;
  logic             lbp_valid;
  logic [13:0]      lbp_addr;
  logic [7:0]       lbp_data;
  logic             finish;
  logic             hist_valid;
  logic             hist_ready;
  logic [7:0]       hist_bin;
  logic [CNT_W-1:0] hist_count;
  logic             hist_last;
  logic [CNT_W-1:0] pix_count;
  logic             proto_err;
  logic             done;

  typedef struct packed {
    logic [7:0]       bin;
    logic [CNT_W-1:0] cnt;
    logic             last;
  } beat_t;

  beat_t exp_q[$];
  int    model [256];
  int    model_pix;
  bit    fin_seen;
  int    checks = 0;
  int    errors = 0;

  lbp_histogram dut (
    .clk        (clk),
    .reset      (reset),
    .lbp_valid  (lbp_valid),
    .lbp_addr   (lbp_addr),
    .lbp_data   (lbp_data),
    .finish     (finish),
    .hist_valid (hist_valid),
    .hist_ready (hist_ready),
    .hist_bin   (hist_bin),
    .hist_count (hist_count),
    .hist_last  (hist_last),
    .pix_count  (pix_count),
    .proto_err  (proto_err),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic bit tb_interior(input int a);
    int r;
    int c;
    r = a / 128;
    c = a % 128;
    return r >= 1 && r <= 126 && c >= 1 && c <= 126;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string nm);
    checks++;
    if ({hist_valid, hist_bin, hist_count, hist_last,
         pix_count, proto_err, done} !== '0) begin
      errors++;
      $display("FAIL %s: v=%b bin=%0d cnt=%0d last=%b pix=%0d err=%b done=%b, want all 0",
               nm, hist_valid, hist_bin, hist_count, hist_last,
               pix_count, proto_err, done);
    end
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    lbp_valid  = 1'b0;
    finish     = 1'b0;
    hist_ready = 1'b0;
    lbp_addr   = '0;
    lbp_data   = '0;
    #1;
    chk_zero("reset_outputs");
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = 0;
    model_pix = 0;
    fin_seen  = 1'b0;
    exp_q.delete();
    step();
  endtask

  // Drive one result for one cycle; caller deasserts lbp_valid.
  task automatic send(input int addr, input int data);
    lbp_valid = 1'b1;
    lbp_addr  = 14'(addr);
    lbp_data  = 8'(data);
    if (tb_interior(addr) && !fin_seen) begin
      model[data]++;
      model_pix++;
    end
    step();
  endtask

  task automatic chk_pix(input string nm);
    checks++;
    if (pix_count !== CNT_W'(model_pix)) begin
      errors++;
      $display("FAIL %s pix_count: got %0d want %0d",
               nm, pix_count, model_pix);
    end
  endtask

  task automatic chk_err(input string nm, input logic want);
    checks++;
    if (proto_err !== want) begin
      errors++;
      $display("FAIL %s proto_err: got %b want %b",
               nm, proto_err, want);
    end
  endtask

  // Raise finish and check first-beat latency of 3 cycles.
  task automatic start_finish(input string nm);
    finish = 1'b1;
    step();
    fin_seen = 1'b1;
    step();
    checks++;
    if (hist_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s early_valid: got %b want 0", nm, hist_valid);
    end
    step();
    checks++;
    if (hist_valid !== 1'b1 || hist_bin !== 8'd0) begin
      errors++;
      $display("FAIL %s first_beat: valid=%b bin=%0d want 1/0",
               nm, hist_valid, hist_bin);
    end
  endtask

  // Drain against the model; optional stall at one bin and
  // optional abort after a number of handshakes.
  task automatic drain(input string nm, input int stall_bin,
                       input int stall_len, input int abort_after);
    int    left;
    int    pops;
    int    budget;
    beat_t e;
    left   = stall_len;
    pops   = 0;
    budget = 3000;
    for (int b = 0; b < 256; b++) begin
      e.bin  = 8'(b);
      e.cnt  = CNT_W'(model[b]);
      e.last = (b == 255);
      exp_q.push_back(e);
    end
    while (exp_q.size() > 0 && budget > 0 &&
           !(abort_after >= 0 && pops == abort_after)) begin
      hist_ready = 1'b1;
      if (hist_valid) begin
        e = exp_q[0];
        checks++;
        if (hist_bin !== e.bin || hist_count !== e.cnt ||
            hist_last !== e.last) begin
          errors++;
          $display("FAIL %s beat: got bin=%0d cnt=%0d last=%b want bin=%0d cnt=%0d last=%b",
                   nm, hist_bin, hist_count, hist_last,
                   e.bin, e.cnt, e.last);
        end
        if (int'(hist_bin) == stall_bin && left > 0) begin
          hist_ready = 1'b0;
          left--;
        end
        if (hist_ready) begin
          void'(exp_q.pop_front());
          pops++;
        end
      end
      step();
      budget--;
    end
    hist_ready = 1'b0;
    if (budget == 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: %0d beats left, want 0",
               nm, exp_q.size());
    end else if (abort_after < 0) begin
      checks++;
      if (done !== 1'b1 || hist_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s done: done=%b valid=%b want 1/0",
                 nm, done, hist_valid);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    chk_zero("post_reset");
  endtask

  task automatic test_empty_frame();
    do_reset();
    start_finish("empty");
    drain("empty", -1, 0, -1);
    chk_err("empty", 1'b0);
    chk_pix("empty");
  endtask

  task automatic test_single();
    do_reset();
    send(129, 8'h5A);
    lbp_valid = 1'b0;
    step();
    chk_pix("single");
    start_finish("single");
    drain("single", -1, 0, -1);
    chk_err("single", 1'b0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    send(129, 8'hFF);
    send(130, 8'hFF);
    send(131, 8'hFF);
    send(132, 8'h10);
    send(133, 8'h10);
    lbp_valid = 1'b0;
    step();
    chk_pix("b2b");
    start_finish("b2b");
    drain("b2b", -1, 0, -1);
    chk_err("b2b", 1'b0);
  endtask

  task automatic test_raster();
    int n;
    n = 0;
    do_reset();
    for (int r = 1; r <= 126; r++) begin
      for (int c = 1; c <= 126; c++) begin
        send(r * 128 + c, 0);
        lbp_valid = 1'b0;
        repeat (n % 3) step();
        n++;
      end
    end
    step();
    chk_pix("raster");
    chk_err("raster", 1'b0);
    start_finish("raster");
    drain("raster", -1, 0, -1);
  endtask

  task automatic test_errors();
    do_reset();
    send(0, 5);
    lbp_valid = 1'b0;
    step();
    chk_err("addr0", 1'b1);
    chk_pix("addr0");
    do_reset();
    send(127, 6);
    lbp_valid = 1'b0;
    step();
    chk_err("addr127", 1'b1);
    chk_pix("addr127");
    do_reset();
    send(129, 7);
    lbp_valid = 1'b0;
    finish = 1'b1;
    step();
    fin_seen = 1'b1;
    chk_err("pre_late", 1'b0);
    send(130, 7);
    lbp_valid = 1'b0;
    step();
    chk_err("late", 1'b1);
    chk_pix("late");
    drain("late", -1, 0, -1);
  endtask

  task automatic test_backpressure_reset();
    do_reset();
    send(129, 3);
    send(300, 3);
    send(400, 4);
    lbp_valid = 1'b0;
    step();
    start_finish("stall");
    drain("stall", 3, 5, -1);
    do_reset();
    send(200, 9);
    lbp_valid = 1'b0;
    step();
    start_finish("abort");
    drain("abort", -1, 0, 10);
    reset = 1'b1;
    #1;
    chk_zero("mid_drain_reset");
    do_reset();
    send(129, 1);
    send(129, 1);
    send(1000, 200);
    lbp_valid = 1'b0;
    step();
    chk_pix("new_frame");
    start_finish("new_frame");
    drain("new_frame", -1, 0, -1);
    chk_err("new_frame", 1'b0);
  endtask

  initial begin
    test_reset();
    test_empty_frame();
    test_single();
    test_back_to_back();
    test_raster();
    test_errors();
    test_backpressure_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
